elastic_alu_pipeline: RTL and testbench
=======================================

Name: elastic_alu_pipeline

Overview:
- Parametrised successor to the fixed three-stage pipeline.
- Combines the 2-bit-select ALU with a STAGES-deep valid/ready elastic pipeline, supporting backpressure, bubble collapsing, flush and an occupancy count.
- Sits between an operand producer and a result consumer in the core datapath, and is instantiated in the top level with probes on all ports.

Parameters:
- DWIDTH, 32, operand/result width in bits (>=1).
- STAGES, 3, number of register stages, i.e. latency with no stalls (>=1).
- CWIDTH, $clog2(STAGES+1), occupancy counter width (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-low: state clears on a rising clk edge while rst==0.
- valid_i  input  1  upstream presents an operation.
- ready_o  output  1  pipeline accepts the operation this cycle.
- sel_i  input  2  ALU op: 00 ADD, 01 SUB (op1-op2), 10 AND, 11 OR.
- op1_i  input  DWIDTH  operand 1.
- op2_i  input  DWIDTH  operand 2.
- flush_i  input  1  synchronous discard of all in-flight entries.
- valid_o  output  1  result available at last stage.
- ready_i  input  1  downstream accepts the result.
- res_o  output  DWIDTH  result of the oldest entry.
- zero_o  output  1  res_o == 0 (qualified by valid_o).
- neg_o  output  1  res_o[DWIDTH-1].
- occupancy_o  output  CWIDTH  number of valid stages.

Behaviour:
- Arithmetic: computed combinationally from inputs and captured into stage 0. ADD/SUB wrap modulo 2^DWIDTH, no carry/overflow out. zero/neg flags are computed from the result and carried with it through the stages.
- Stage k holds {valid[k], res, zero, neg}. Stage STAGES-1 drives valid_o/res_o/zero_o/neg_o directly from registers; no combinational path from inputs to outputs.
- Advance rule:
  - adv[STAGES-1] = !valid[STAGES-1] || ready_i.
  - adv[k] = !valid[k] || adv[k+1].
  - ready_o = adv[0] && !flush_i.
  - This collapses bubbles and allows full throughput (1 op/cycle) when ready_i is held high.
- Update: when adv[k], stage k loads from stage k-1 (stage 0 loads from the input with valid = valid_i && ready_o). Otherwise stage k holds. The payload is loaded only when the incoming valid is 1; the payload of an invalid stage is don't-care but must not change outputs: res_o/zero_o/neg_o hold their last value when valid_o==0.
- Handshake:
  - Transfer in occurs when valid_i && ready_o.
  - Transfer out occurs when valid_o && ready_i.
  - While valid_o && !ready_i, res_o/zero_o/neg_o are stable.
  - ready_o may depend combinationally on ready_i (chain through adv).
- Latency: STAGES cycles from accept to valid_o when unstalled. Ordering is strictly FIFO; no entry is dropped or duplicated.
- occupancy_o: registered count of valid stages. It updates as count + in_xfer - out_xfer, and is 0 after flush/reset. It never exceeds STAGES.
- flush_i (when rst==1): next edge clears all valid bits and occupancy; payload registers hold. ready_o==0 during flush, so input is not accepted. An output transfer in the flush cycle still counts as consumed by the downstream, but the entry is gone either way.
- Reset (rst==0 at edge): all valid=0, all payload=0, so valid_o=0, res_o=0, zero_o=0, neg_o=0, occupancy_o=0. Reset has priority over flush and valid_i, and applies mid-operation (in-flight data discarded). ready_o is combinational and equals 1 during reset cycles only if !flush_i. Upstream must not count a transfer while rst==0; the bench checks nothing is captured.
- STAGES==1: single register stage, ready_o = !valid_o || ready_i.

Decomposition:
- Package alu_pkg: typedef enum logic [1:0] alu_op_e {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR}, and a struct stage_payload_t {res, zero, neg} parametrised via DWIDTH localparam or width-agnostic function alu_compute().
- Sub-module pipe_stage: one valid+payload register with load-enable and synchronous clear (flush/reset), instantiated STAGES times with a generate loop. ALU logic stays inline in the top of the block.

Test Plan:
- Reset: hold rst=0 for 2 cycles with valid_i=1 -> valid_o=0, res_o=0, occupancy_o=0; release, no spurious output.
- Streaming, STAGES=3, ready_i=1: issue ADD 5+7, SUB 3-5, AND 0xF0F0&0x0FF0, OR 0x1|0x2 on consecutive cycles -> outputs 12, 0xFFFFFFFE (neg=1), 0x00F0, 0x3 on cycles 3..6, ready_o stays 1.
- Backpressure: fill with 4 ops, ready_i=0 -> ready_o drops after 3 accepts, occupancy_o=3, res_o stable. Raise ready_i -> all 4 emerge in order, no loss.
- Bubble collapse: one op, then ready_i=0 for 5 cycles, then a second op -> second op advances until adjacent to the first, occupancy_o=2.
- Flush: 3 ops in flight, pulse flush_i one cycle -> next cycle valid_o=0, occupancy_o=0, ready_o=0 during flush; following op emerges after 3 cycles.
- Wrap/zero: ADD 0xFFFFFFFF+1 -> res_o=0, zero_o=1, neg_o=0. Reset asserted mid-stream -> all in-flight entries discarded.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the elastic ALU pipeline.
// Holds the ALU opcode enum and the default-width stage payload bundle.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR
  } alu_op_e;

  localparam int DWIDTH_DEF = 32;

  typedef struct packed {
    logic [DWIDTH_DEF-1:0] res;
    logic                  zero;
    logic                  neg;
  } stage_payload_t;

endpackage

// File: rtl/elastic_alu_pipeline_if.sv
// Operand/result handshake bundle of the elastic ALU pipeline.
// master = producer/consumer side, slave = pipeline side.
interface elastic_alu_pipeline_if #(
  parameter int DWIDTH = 32
);
  logic              valid_i;
  logic              ready_o;
  logic [1:0]        sel_i;
  logic [DWIDTH-1:0] op1_i;
  logic [DWIDTH-1:0] op2_i;
  logic              flush_i;
  logic              valid_o;
  logic              ready_i;
  logic [DWIDTH-1:0] res_o;
  logic              zero_o;
  logic              neg_o;

  modport master (
    output valid_i, sel_i, op1_i, op2_i,
    output flush_i, ready_i,
    input  ready_o, valid_o, res_o,
    input  zero_o, neg_o
  );

  modport slave (
    input  valid_i, sel_i, op1_i, op2_i,
    input  flush_i, ready_i,
    output ready_o, valid_o, res_o,
    output zero_o, neg_o
  );
endinterface

// File: rtl/pipe_stage.sv
// One elastic stage: valid bit plus payload register.
// Ports: clk, rst (sync, active-low), clr_i, ld_i, valid_i/data_i in, valid_o/data_o out.
module pipe_stage #(
  parameter int PW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          ld_i,
  input  logic          valid_i,
  input  logic [PW-1:0] data_i,
  output logic          valid_o,
  output logic [PW-1:0] data_o
);
  logic          valid_q;
  logic [PW-1:0] data_q;

  // Payload only moves with a valid entry so that
  // an idle stage keeps presenting its last result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end else if (ld_i) begin
      valid_q <= valid_i;
      if (valid_i) data_q <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/elastic_alu_pipeline.sv
// STAGES-deep valid/ready ALU pipeline with bubble collapse, flush, occupancy.
// Ports: clk, rst (sync, active-low), bus (slave handshake bundle), occupancy_o.
module elastic_alu_pipeline
  import alu_pkg::*;
#(
  parameter  int DWIDTH = 32,
  parameter  int STAGES = 3,
  localparam int CWIDTH = $clog2(STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  elastic_alu_pipeline_if.slave bus,
  output logic [CWIDTH-1:0]     occupancy_o
);
  typedef struct packed {
    logic [DWIDTH-1:0] res;
    logic              zero;
    logic              neg;
  } payload_t;

  localparam int PW = $bits(payload_t);

  alu_op_e           op;
  logic [DWIDTH-1:0] alu_res;
  payload_t          in_pl;
  logic              in_v;
  logic              in_x;
  logic              out_x;
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] adv;
  payload_t          pl_q [STAGES];
  logic [CWIDTH-1:0] occupancy_q;
  logic [CWIDTH-1:0] occupancy_d;

  assign op = alu_op_e'(bus.sel_i);

  always_comb begin
    alu_res = '0;
    unique case (op)
      ALU_ADD: alu_res = bus.op1_i + bus.op2_i;
      ALU_SUB: alu_res = bus.op1_i - bus.op2_i;
      ALU_AND: alu_res = bus.op1_i & bus.op2_i;
      ALU_OR:  alu_res = bus.op1_i | bus.op2_i;
    endcase
  end

  assign in_pl.res  = alu_res;
  assign in_pl.zero = (alu_res == '0);
  assign in_pl.neg  = alu_res[DWIDTH-1];

  // A stage may advance when it is empty or its successor
  // advances; this collapses bubbles behind a stall.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = !v_q[STAGES-1] || bus.ready_i;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv[k] = !v_q[k] || adv[k+1];
    end
  end

  assign bus.ready_o = adv[0] && !bus.flush_i;
  assign in_x        = bus.valid_i && bus.ready_o;
  assign in_v        = in_x;
  assign out_x       = bus.valid_o && bus.ready_i;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      pipe_stage #(.PW(PW)) u_stage (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (bus.flush_i),
        .ld_i   (adv[k]),
        .valid_i(in_v),
        .data_i (in_pl),
        .valid_o(v_q[k]),
        .data_o (pl_q[k])
      );
    end else begin : g_body
      pipe_stage #(.PW(PW)) u_stage (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (bus.flush_i),
        .ld_i   (adv[k]),
        .valid_i(v_q[k-1]),
        .data_i (pl_q[k-1]),
        .valid_o(v_q[k]),
        .data_o (pl_q[k])
      );
    end
  end

  assign occupancy_d = occupancy_q
                     + CWIDTH'(in_x)
                     - CWIDTH'(out_x);

  always_ff @(posedge clk) begin
    if (!rst) begin
      occupancy_q <= '0;
    end else if (bus.flush_i) begin
      occupancy_q <= '0;
    end else begin
      occupancy_q <= occupancy_d;
    end
  end

  assign occupancy_o = occupancy_q;
  assign bus.valid_o = v_q[STAGES-1];
  assign bus.res_o   = pl_q[STAGES-1].res;
  assign bus.zero_o  = pl_q[STAGES-1].zero;
  assign bus.neg_o   = pl_q[STAGES-1].neg;
endmodule

// File: tb/tb_elastic_alu_pipeline.sv
// Directed self-checking bench for elastic_alu_pipeline (DWIDTH=32, STAGES=3).
// Each scenario task drives vectors and compares against hand-computed values.
module tb_elastic_alu_pipeline;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] occ;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  elastic_alu_pipeline_if #(.DWIDTH(32)) bus ();

  elastic_alu_pipeline #(.DWIDTH(32), .STAGES(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .occupancy_o(occ)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s,
                       input logic [31:0] a, input logic [31:0] b);
    bus.valid_i = v;
    bus.sel_i   = s;
    bus.op1_i   = a;
    bus.op2_i   = b;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.ready_i = 1'b1;
    bus.flush_i = 1'b0;
    drive(1'b1, 2'd0, 32'd5, 32'd7);
    cyc();
    cyc();
    checks++;
    if (bus.valid_o !== 1'b0 || bus.res_o !== 32'd0 || occ !== 2'd0
        || bus.zero_o !== 1'b0 || bus.neg_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_state valid=%b res=%h occ=%0d z=%b n=%b want 0/0/0/0/0",
               bus.valid_o, bus.res_o, occ, bus.zero_o, bus.neg_o);
    end
    rst = 1'b1;
    drive(1'b0, 2'd0, 32'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++;
      if (bus.valid_o !== 1'b0 || occ !== 2'd0) begin
        failures++;
        $display("FAIL reset_release_%0d valid=%b occ=%0d want 0/0", i, bus.valid_o, occ);
      end
    end
  endtask

  task automatic test_stream();
    logic [31:0] a[4];
    logic [31:0] b[4];
    logic [31:0] r[4];
    logic [1:0]  s[4];
    logic        n[4];
    a = '{32'd5, 32'd3, 32'h0000F0F0, 32'h1};
    b = '{32'd7, 32'd5, 32'h00000FF0, 32'h2};
    r = '{32'd12, 32'hFFFFFFFE, 32'h000000F0, 32'h3};
    s = '{2'd0, 2'd1, 2'd2, 2'd3};
    n = '{1'b0, 1'b1, 1'b0, 1'b0};
    bus.ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) drive(1'b1, s[i], a[i], b[i]);
      else drive(1'b0, 2'd0, 32'd0, 32'd0);
      #1;
      if (i < 4) begin
        checks++;
        if (bus.ready_o !== 1'b1) begin
          failures++;
          $display("FAIL stream_ready_%0d got=%b want=1", i, bus.ready_o);
        end
      end
      cyc();
      if (i >= 2 && i < 6) begin
        checks++;
        if (bus.valid_o !== 1'b1 || bus.res_o !== r[i-2]
            || bus.neg_o !== n[i-2] || bus.zero_o !== 1'b0) begin
          failures++;
          $display("FAIL stream_out_%0d valid=%b res=%h n=%b z=%b want 1/%h/%b/0",
                   i - 2, bus.valid_o, bus.res_o, bus.neg_o, bus.zero_o,
                   r[i-2], n[i-2]);
        end
      end
      if (i == 2) begin
        checks++;
        if (occ !== 2'd3) begin
          failures++;
          $display("FAIL stream_occ got=%0d want=3", occ);
        end
      end
      if (i == 7) begin
        checks++;
        if (bus.valid_o !== 1'b0 || occ !== 2'd0) begin
          failures++;
          $display("FAIL stream_drain valid=%b occ=%0d want 0/0", bus.valid_o, occ);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int   acc = 0;
    int   outn = 0;
    logic rdy;
    logic vi;
    bus.ready_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      vi = (acc < 4);
      drive(vi, 2'd0, 32'(acc + 10), 32'(acc));
      #1;
      rdy = bus.ready_o && vi;
      cyc();
      if (rdy) acc++;
      if (k >= 2) begin
        checks++;
        if (bus.valid_o !== 1'b1 || bus.res_o !== 32'd10) begin
          failures++;
          $display("FAIL bp_stall_%0d valid=%b res=%h want 1/0000000a",
                   k, bus.valid_o, bus.res_o);
        end
      end
    end
    checks++;
    if (acc != 3 || occ !== 2'd3 || bus.ready_o !== 1'b0) begin
      failures++;
      $display("FAIL bp_full accepted=%0d occ=%0d ready=%b want 3/3/0",
               acc, occ, bus.ready_o);
    end
    bus.ready_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      vi = (acc < 4);
      drive(vi, 2'd0, 32'(acc + 10), 32'(acc));
      #1;
      rdy = bus.ready_o && vi;
      if (bus.valid_o === 1'b1) begin
        checks++;
        if (bus.res_o !== 32'(2 * outn + 10)) begin
          failures++;
          $display("FAIL bp_order_%0d got=%h want=%h",
                   outn, bus.res_o, 32'(2 * outn + 10));
        end
        outn++;
      end
      cyc();
      if (rdy) acc++;
    end
    checks++;
    if (outn != 4 || acc != 4 || occ !== 2'd0) begin
      failures++;
      $display("FAIL bp_count out=%0d in=%0d occ=%0d want 4/4/0", outn, acc, occ);
    end
  endtask

  task automatic test_bubble();
    bus.ready_i = 1'b0;
    drive(1'b1, 2'd0, 32'd100, 32'd1);
    cyc();
    drive(1'b0, 2'd0, 32'd0, 32'd0);
    for (int i = 0; i < 5; i++) cyc();
    drive(1'b1, 2'd1, 32'd50, 32'd8);
    cyc();
    drive(1'b0, 2'd0, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) cyc();
    checks++;
    if (occ !== 2'd2 || bus.valid_o !== 1'b1 || bus.res_o !== 32'd101
        || bus.ready_o !== 1'b1) begin
      failures++;
      $display("FAIL bubble_stall occ=%0d valid=%b res=%h ready=%b want 2/1/00000065/1",
               occ, bus.valid_o, bus.res_o, bus.ready_o);
    end
    bus.ready_i = 1'b1;
    cyc();
    checks++;
    if (bus.valid_o !== 1'b1 || bus.res_o !== 32'd42 || occ !== 2'd1) begin
      failures++;
      $display("FAIL bubble_second valid=%b res=%h occ=%0d want 1/0000002a/1",
               bus.valid_o, bus.res_o, occ);
    end
    cyc();
    checks++;
    if (bus.valid_o !== 1'b0 || occ !== 2'd0) begin
      failures++;
      $display("FAIL bubble_drain valid=%b occ=%0d want 0/0", bus.valid_o, occ);
    end
  endtask

  task automatic test_flush();
    bus.ready_i = 1'b0;
    for (int j = 0; j < 3; j++) begin
      drive(1'b1, 2'd0, 32'(j + 1), 32'd0);
      cyc();
    end
    checks++;
    if (occ !== 2'd3 || bus.res_o !== 32'd1) begin
      failures++;
      $display("FAIL flush_fill occ=%0d res=%h want 3/00000001", occ, bus.res_o);
    end
    bus.ready_i = 1'b1;
    bus.flush_i = 1'b1;
    drive(1'b1, 2'd0, 32'd77, 32'd0);
    #1;
    checks++;
    if (bus.ready_o !== 1'b0) begin
      failures++;
      $display("FAIL flush_ready got=%b want=0", bus.ready_o);
    end
    cyc();
    bus.flush_i = 1'b0;
    drive(1'b0, 2'd0, 32'd0, 32'd0);
    checks++;
    if (bus.valid_o !== 1'b0 || occ !== 2'd0 || bus.res_o !== 32'd1) begin
      failures++;
      $display("FAIL flush_clear valid=%b occ=%0d res=%h want 0/0/00000001",
               bus.valid_o, occ, bus.res_o);
    end
    drive(1'b1, 2'd2, 32'hFF00FF00, 32'h0F0F0F0F);
    cyc();
    drive(1'b0, 2'd0, 32'd0, 32'd0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (bus.valid_o !== 1'b0) begin
        failures++;
        $display("FAIL flush_early_%0d valid=%b want=0", i, bus.valid_o);
      end
      cyc();
    end
    checks++;
    if (bus.valid_o !== 1'b1 || bus.res_o !== 32'h0F000F00) begin
      failures++;
      $display("FAIL flush_after valid=%b res=%h want 1/0f000f00",
               bus.valid_o, bus.res_o);
    end
    cyc();
  endtask

  task automatic test_wrap();
    bus.ready_i = 1'b1;
    drive(1'b1, 2'd0, 32'hFFFFFFFF, 32'd1);
    cyc();
    drive(1'b0, 2'd0, 32'd0, 32'd0);
    cyc();
    cyc();
    checks++;
    if (bus.valid_o !== 1'b1 || bus.res_o !== 32'd0
        || bus.zero_o !== 1'b1 || bus.neg_o !== 1'b0) begin
      failures++;
      $display("FAIL wrap valid=%b res=%h z=%b n=%b want 1/00000000/1/0",
               bus.valid_o, bus.res_o, bus.zero_o, bus.neg_o);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    bus.ready_i = 1'b1;
    drive(1'b1, 2'd3, 32'h80000000, 32'd4);
    cyc();
    drive(1'b1, 2'd0, 32'd9, 32'd9);
    cyc();
    rst = 1'b0;
    cyc();
    checks++;
    if (bus.valid_o !== 1'b0 || occ !== 2'd0 || bus.res_o !== 32'd0) begin
      failures++;
      $display("FAIL rstmid_state valid=%b occ=%0d res=%h want 0/0/0",
               bus.valid_o, occ, bus.res_o);
    end
    rst = 1'b1;
    drive(1'b0, 2'd0, 32'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++;
      if (bus.valid_o !== 1'b0 || occ !== 2'd0) begin
        failures++;
        $display("FAIL rstmid_drop_%0d valid=%b occ=%0d want 0/0", i, bus.valid_o, occ);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.flush_i = 1'b0;
    bus.ready_i = 1'b1;
    drive(1'b0, 2'd0, 32'd0, 32'd0);
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_flush();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
